// File: rtl/multicycle_controller.sv
// Multi-cycle MIPS control FSM: sequences fetch/decode/execute/memory/writeback over a shared
// memory port, stretches memory states on mem_ready, counts retired instructions and halts on HALT_OP.
module multicycle_controller #(
    parameter int         CNT_W   = 32,
    parameter logic [5:0] HALT_OP = 6'b111111
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [5:0]       opcode,
    input  logic [5:0]       func,
    input  logic             ALUZero,
    input  logic             mem_ready,
    output logic             PCWrite,
    output logic             PCWriteCond,
    output logic             IorD,
    output logic             MemRead,
    output logic             MemWrite,
    output logic             IRWrite,
    output logic             RegWrite,
    output logic [1:0]       RegDst,
    output logic [1:0]       MemToReg,
    output logic             ALUSrcA,
    output logic [1:0]       ALUSrcB,
    output logic [2:0]       ALUoperation,
    output logic [1:0]       PCSrc,
    output logic [CNT_W-1:0] inst_count,
    output logic             halted,
    output logic             illegal
);

    typedef enum logic [3:0] {
        S_FETCH, S_DECODE, S_MEM_ADR, S_MEM_RD, S_LW_WB, S_MEM_WR, S_R_EX, S_R_WB,
        S_I_EX, S_I_WB, S_BEQ, S_J, S_JAL, S_JR, S_HALT
    } state_t;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       iord;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_write;
        logic [1:0] reg_dst;
        logic [1:0] mem_to_reg;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [2:0] alu_op;
        logic [1:0] pc_src;
        logic       halted;
    } ctrl_t;

    state_t           state_reg, state_next;
    ctrl_t            ctrl_reg;
    logic [CNT_W-1:0] count_reg;
    logic             illegal_reg, illegal_next;

    // The branch decision itself is made by the datapath's PC enable logic.
    logic unused_alu_zero;
    assign unused_alu_zero = ALUZero;

    function automatic ctrl_t ctrl_for(input state_t s, input logic [5:0] op, input logic [5:0] fn);
        ctrl_t c;
        c = '0;
        case (s)
            S_FETCH:   begin c.mem_read = 1'b1; c.alu_src_b = 2'b01; c.alu_op = 3'b010;
                             c.ir_write = 1'b1; c.pc_write = 1'b1; end
            S_DECODE:  begin c.alu_src_b = 2'b11; c.alu_op = 3'b010; end
            S_MEM_ADR: begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10; c.alu_op = 3'b010; end
            S_MEM_RD:  begin c.mem_read = 1'b1; c.iord = 1'b1; end
            S_LW_WB:   begin c.mem_to_reg = 2'b01; c.reg_write = 1'b1; end
            S_MEM_WR:  begin c.mem_write = 1'b1; c.iord = 1'b1; end
            S_R_EX: begin
                c.alu_src_a = 1'b1;
                case (fn)
                    6'b100010: c.alu_op = 3'b110;
                    6'b100100: c.alu_op = 3'b000;
                    6'b100101: c.alu_op = 3'b001;
                    6'b101010: c.alu_op = 3'b111;
                    default:   c.alu_op = 3'b010;
                endcase
            end
            S_R_WB:    begin c.reg_dst = 2'b01; c.reg_write = 1'b1; end
            S_I_EX:    begin c.alu_src_a = 1'b1; c.alu_src_b = 2'b10;
                             c.alu_op = (op == 6'b001010) ? 3'b111 : 3'b010; end
            S_I_WB:    c.reg_write = 1'b1;
            S_BEQ:     begin c.alu_src_a = 1'b1; c.alu_op = 3'b110; c.pc_src = 2'b01;
                             c.pc_write_cond = 1'b1; end
            S_J:       begin c.pc_src = 2'b10; c.pc_write = 1'b1; end
            S_JAL:     begin c.pc_src = 2'b10; c.pc_write = 1'b1; c.reg_dst = 2'b10;
                             c.mem_to_reg = 2'b10; c.reg_write = 1'b1; end
            S_JR:      begin c.pc_src = 2'b11; c.pc_write = 1'b1; end
            S_HALT:    c.halted = 1'b1;
            default:   c = '0;
        endcase
        return c;
    endfunction

    always_comb begin
        state_next   = state_reg;
        illegal_next = 1'b0;
        case (state_reg)
            S_FETCH:   if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                if (opcode == HALT_OP) begin
                    state_next = S_HALT;
                end else begin
                    case (opcode)
                        6'b000000: begin
                            case (func)
                                6'b001000: state_next = S_JR;
                                6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010:
                                           state_next = S_R_EX;
                                default: begin
                                    state_next   = S_FETCH;
                                    illegal_next = 1'b1;
                                end
                            endcase
                        end
                        6'b100011, 6'b101011: state_next = S_MEM_ADR;
                        6'b001000, 6'b001010: state_next = S_I_EX;
                        6'b000100:            state_next = S_BEQ;
                        6'b000010:            state_next = S_J;
                        6'b000011:            state_next = S_JAL;
                        default: begin
                            state_next   = S_FETCH;
                            illegal_next = 1'b1;
                        end
                    endcase
                end
            end
            S_MEM_ADR: state_next = (opcode == 6'b101011) ? S_MEM_WR : S_MEM_RD;
            S_MEM_RD:  if (mem_ready) state_next = S_LW_WB;
            S_MEM_WR:  if (mem_ready) state_next = S_FETCH;
            S_R_EX:    state_next = S_R_WB;
            S_I_EX:    state_next = S_I_WB;
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_FETCH;
        endcase
    end

    // Controls are registered from the next state so each state's outputs appear glitch-free.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg   <= S_FETCH;
            ctrl_reg    <= ctrl_for(S_FETCH, opcode, func);
            count_reg   <= '0;
            illegal_reg <= 1'b0;
        end else begin
            state_reg   <= state_next;
            ctrl_reg    <= ctrl_for(state_next, opcode, func);
            illegal_reg <= illegal_next;
            if (state_next == S_FETCH && state_reg != S_FETCH)
                count_reg <= count_reg + CNT_W'(1);
        end
    end

    // Everything is masked during reset; fetch and load-writeback strobes wait on mem_ready.
    assign PCWrite      = rst & ctrl_reg.pc_write & (mem_ready | (state_reg != S_FETCH));
    assign IRWrite      = rst & ctrl_reg.ir_write & mem_ready;
    assign RegWrite     = rst & ctrl_reg.reg_write & (mem_ready | (state_reg != S_LW_WB));
    assign PCWriteCond  = rst & ctrl_reg.pc_write_cond;
    assign IorD         = rst & ctrl_reg.iord;
    assign MemRead      = rst & ctrl_reg.mem_read;
    assign MemWrite     = rst & ctrl_reg.mem_write;
    assign RegDst       = {2{rst}} & ctrl_reg.reg_dst;
    assign MemToReg     = {2{rst}} & ctrl_reg.mem_to_reg;
    assign ALUSrcA      = rst & ctrl_reg.alu_src_a;
    assign ALUSrcB      = {2{rst}} & ctrl_reg.alu_src_b;
    assign ALUoperation = {3{rst}} & ctrl_reg.alu_op;
    assign PCSrc        = {2{rst}} & ctrl_reg.pc_src;
    assign halted       = rst & ctrl_reg.halted;
    assign illegal      = rst & illegal_reg;
    assign inst_count   = rst ? count_reg : '0;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: directed instruction sequences then a random instruction
// stream, compared cycle by cycle against a per-instruction phase model.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [5:0]  opcode = '0, func = '0;
    logic        ALUZero = 1'b0, mem_ready = 1'b0;

    logic        PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, ALUSrcA, halted, illegal;
    logic [1:0]  RegDst, MemToReg, ALUSrcB, PCSrc;
    logic [2:0]  ALUoperation;
    logic [31:0] inst_count;

    logic        PCWrite_w, PCWriteCond_w, IorD_w, MemRead_w, MemWrite_w, IRWrite_w, RegWrite_w;
    logic        ALUSrcA_w, halted_w, illegal_w;
    logic [1:0]  RegDst_w, MemToReg_w, ALUSrcB_w, PCSrc_w;
    logic [2:0]  ALUoperation_w;
    logic [2:0]  inst_count_w;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ALUZero(ALUZero), .mem_ready(mem_ready),
        .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .MemRead(MemRead),
        .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite), .RegDst(RegDst),
        .MemToReg(MemToReg), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUoperation(ALUoperation),
        .PCSrc(PCSrc), .inst_count(inst_count), .halted(halted), .illegal(illegal)
    );

    // Narrow counter instance so wrap-around is reached in a short run.
    multicycle_controller #(.CNT_W(3)) dut_w (
        .clk(clk), .rst(rst), .opcode(opcode), .func(func), .ALUZero(ALUZero), .mem_ready(mem_ready),
        .PCWrite(PCWrite_w), .PCWriteCond(PCWriteCond_w), .IorD(IorD_w), .MemRead(MemRead_w),
        .MemWrite(MemWrite_w), .IRWrite(IRWrite_w), .RegWrite(RegWrite_w), .RegDst(RegDst_w),
        .MemToReg(MemToReg_w), .ALUSrcA(ALUSrcA_w), .ALUSrcB(ALUSrcB_w), .ALUoperation(ALUoperation_w),
        .PCSrc(PCSrc_w), .inst_count(inst_count_w), .halted(halted_w), .illegal(illegal_w)
    );

    logic [19:0] obs, obs_w;
    assign obs   = {PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite, RegDst,
                    MemToReg, ALUSrcA, ALUSrcB, ALUoperation, PCSrc, halted};
    assign obs_w = {PCWrite_w, PCWriteCond_w, IorD_w, MemRead_w, MemWrite_w, IRWrite_w, RegWrite_w,
                    RegDst_w, MemToReg_w, ALUSrcA_w, ALUSrcB_w, ALUoperation_w, PCSrc_w, halted_w};

    typedef enum {P_FETCH, P_DECODE, P_MEM_ADR, P_MEM_RD, P_LW_WB, P_MEM_WR, P_R_EX, P_R_WB,
                  P_I_EX, P_I_WB, P_BEQ, P_J, P_JAL, P_JR, P_HALT} phase_t;
    typedef enum {K_R, K_JR, K_LW, K_SW, K_I, K_BEQ, K_J, K_JAL, K_HALT, K_ILL} kind_t;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] exp_count = '0;
    logic        exp_illegal = 1'b0;

    logic [5:0] r_funcs [5] = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010};
    logic [5:0] bad_ops [5] = '{6'b010101, 6'b000001, 6'b110000, 6'b001111, 6'b100000};
    logic [5:0] bad_fns [4] = '{6'b000000, 6'b100001, 6'b111111, 6'b001001};

    function automatic logic rbit();
        return 1'($urandom_range(0, 1));
    endfunction

    function automatic kind_t classify(input logic [5:0] op, input logic [5:0] fn);
        kind_t k;
        k = K_ILL;
        if (op == 6'b111111) k = K_HALT;
        else if (op == 6'b000000) begin
            if (fn == 6'b001000) k = K_JR;
            else if (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010}) k = K_R;
        end
        else if (op == 6'b100011) k = K_LW;
        else if (op == 6'b101011) k = K_SW;
        else if (op == 6'b001000 || op == 6'b001010) k = K_I;
        else if (op == 6'b000100) k = K_BEQ;
        else if (op == 6'b000010) k = K_J;
        else if (op == 6'b000011) k = K_JAL;
        return k;
    endfunction

    // Expected control word for one cycle of a given instruction phase.
    function automatic logic [19:0] phase_ctrl(input phase_t p, input logic mr,
                                               input logic [5:0] op, input logic [5:0] fn);
        logic pcw, pcwc, iord, mrd, mwr, irw, rw, asa, hlt;
        logic [1:0] rd, m2r, asb, pcs;
        logic [2:0] aop;
        {pcw, pcwc, iord, mrd, mwr, irw, rw, asa, hlt} = '0;
        {rd, m2r, asb, pcs} = '0;
        aop = '0;
        case (p)
            P_FETCH:   begin mrd = 1; asb = 2'b01; aop = 3'b010; irw = mr; pcw = mr; end
            P_DECODE:  begin asb = 2'b11; aop = 3'b010; end
            P_MEM_ADR: begin asa = 1; asb = 2'b10; aop = 3'b010; end
            P_MEM_RD:  begin mrd = 1; iord = 1; end
            P_LW_WB:   begin m2r = 2'b01; rw = mr; end
            P_MEM_WR:  begin mwr = 1; iord = 1; end
            P_R_EX: begin
                asa = 1;
                if (fn == 6'b100000) aop = 3'b010;
                else if (fn == 6'b100010) aop = 3'b110;
                else if (fn == 6'b100100) aop = 3'b000;
                else if (fn == 6'b100101) aop = 3'b001;
                else aop = 3'b111;
            end
            P_R_WB:    begin rd = 2'b01; rw = 1; end
            P_I_EX:    begin asa = 1; asb = 2'b10; aop = (op == 6'b001010) ? 3'b111 : 3'b010; end
            P_I_WB:    rw = 1;
            P_BEQ:     begin asa = 1; aop = 3'b110; pcs = 2'b01; pcwc = 1; end
            P_J:       begin pcs = 2'b10; pcw = 1; end
            P_JAL:     begin pcs = 2'b10; pcw = 1; rd = 2'b10; m2r = 2'b10; rw = 1; end
            P_JR:      begin pcs = 2'b11; pcw = 1; end
            default:   hlt = 1;
        endcase
        return {pcw, pcwc, iord, mrd, mwr, irw, rw, rd, m2r, asa, asb, aop, pcs, hlt};
    endfunction

    task automatic do_cycle(input phase_t p, input logic mr, input logic [5:0] op, input logic [5:0] fn);
        logic [19:0] exp_vec;
        rst = 1'b1; mem_ready = mr; opcode = op; func = fn; ALUZero = rbit();
        exp_vec = phase_ctrl(p, mr, op, fn);
        @(negedge clk);
        checks++;
        assert (obs === exp_vec) else begin
            failures++;
            $error("FAIL ctrl phase=%s observed=%h expected=%h", p.name(), obs, exp_vec);
        end
        checks++;
        assert (obs_w === exp_vec) else begin
            failures++;
            $error("FAIL ctrl_w phase=%s observed=%h expected=%h", p.name(), obs_w, exp_vec);
        end
        checks++;
        assert (inst_count === exp_count) else begin
            failures++;
            $error("FAIL inst_count phase=%s observed=%0d expected=%0d", p.name(), inst_count, exp_count);
        end
        checks++;
        assert (inst_count_w === exp_count[2:0]) else begin
            failures++;
            $error("FAIL inst_count_w phase=%s observed=%0d expected=%0d", p.name(), inst_count_w, exp_count[2:0]);
        end
        checks++;
        assert (illegal === exp_illegal) else begin
            failures++;
            $error("FAIL illegal phase=%s observed=%b expected=%b", p.name(), illegal, exp_illegal);
        end
        @(posedge clk);
        #1;
        exp_illegal = 1'b0;
    endtask

    task automatic do_reset(input int n);
        rst = 1'b0;
        repeat (n) begin
            mem_ready = 1'b1; opcode = 6'($urandom); func = 6'($urandom); ALUZero = rbit();
            @(negedge clk);
            checks++;
            assert (obs === '0 && obs_w === '0) else begin
                failures++;
                $error("FAIL reset_ctrl observed=%h/%h expected=00000", obs, obs_w);
            end
            checks++;
            assert (inst_count === 32'd0 && inst_count_w === 3'd0 && illegal === 1'b0) else begin
                failures++;
                $error("FAIL reset_status observed count=%0d/%0d illegal=%b expected 0/0/0",
                       inst_count, inst_count_w, illegal);
            end
            @(posedge clk);
            #1;
        end
        rst = 1'b1;
        exp_count = '0;
        exp_illegal = 1'b0;
        $display("reset cycles=%0d", n);
    endtask

    task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fstall, input int mstall);
        kind_t k;
        k = classify(op, fn);
        repeat (fstall) do_cycle(P_FETCH, 1'b0, 6'($urandom), 6'($urandom));
        do_cycle(P_FETCH, 1'b1, 6'($urandom), 6'($urandom));
        do_cycle(P_DECODE, rbit(), op, fn);
        case (k)
            K_R:   begin do_cycle(P_R_EX, rbit(), op, fn); do_cycle(P_R_WB, rbit(), op, fn); end
            K_JR:  do_cycle(P_JR, rbit(), op, fn);
            K_LW: begin
                do_cycle(P_MEM_ADR, rbit(), op, fn);
                repeat (mstall) do_cycle(P_MEM_RD, 1'b0, op, fn);
                do_cycle(P_MEM_RD, 1'b1, op, fn);
                do_cycle(P_LW_WB, rbit(), op, fn);
            end
            K_SW: begin
                do_cycle(P_MEM_ADR, rbit(), op, fn);
                repeat (mstall) do_cycle(P_MEM_WR, 1'b0, op, fn);
                do_cycle(P_MEM_WR, 1'b1, op, fn);
            end
            K_I:   begin do_cycle(P_I_EX, rbit(), op, fn); do_cycle(P_I_WB, rbit(), op, fn); end
            K_BEQ: do_cycle(P_BEQ, rbit(), op, fn);
            K_J:   do_cycle(P_J, rbit(), op, fn);
            K_JAL: do_cycle(P_JAL, rbit(), op, fn);
            K_HALT: begin
                repeat (4) do_cycle(P_HALT, rbit(), 6'($urandom), 6'($urandom));
                do_reset(1);
            end
            default: exp_illegal = 1'b1;
        endcase
        if (k != K_HALT) exp_count = exp_count + 32'd1;
        $display("instr op=%b fn=%b kind=%s fstall=%0d mstall=%0d count=%0d",
                 op, fn, k.name(), fstall, mstall, exp_count);
    endtask

    // Start a memory instruction and reset while its memory phase is stalled.
    task automatic abort_mem(input logic [5:0] op);
        phase_t mp;
        mp = (op == 6'b101011) ? P_MEM_WR : P_MEM_RD;
        do_cycle(P_FETCH, 1'b1, 6'($urandom), 6'($urandom));
        do_cycle(P_DECODE, 1'b1, op, 6'($urandom));
        do_cycle(P_MEM_ADR, 1'b1, op, 6'($urandom));
        do_cycle(mp, 1'b0, op, 6'($urandom));
        do_cycle(mp, 1'b0, op, 6'($urandom));
        $display("abort op=%b in %s", op, mp.name());
        do_reset(1);
    endtask

    initial begin
        logic [5:0] op, fn;
        int         sel;
        do_reset(2);
        run_instr(6'b000000, 6'b100000, 0, 0);
        run_instr(6'b100011, 6'($urandom), 0, 3);
        run_instr(6'b000100, 6'($urandom), 0, 0);
        run_instr(6'b000100, 6'($urandom), 1, 0);
        run_instr(6'b000011, 6'($urandom), 0, 0);
        run_instr(6'b000000, 6'b001000, 0, 0);
        run_instr(6'b010101, 6'($urandom), 0, 0);
        run_instr(6'b000000, 6'b100010, 2, 0);
        run_instr(6'b001000, 6'($urandom), 0, 0);
        run_instr(6'b001010, 6'($urandom), 0, 0);
        run_instr(6'b101011, 6'($urandom), 0, 2);
        run_instr(6'b101011, 6'($urandom), 0, 0);
        run_instr(6'b000010, 6'($urandom), 0, 0);
        run_instr(6'b000000, 6'b100100, 0, 0);
        run_instr(6'b000000, 6'b100101, 0, 0);
        run_instr(6'b000000, 6'b101010, 0, 0);
        run_instr(6'b000000, 6'b100001, 0, 0);
        abort_mem(6'b101011);
        abort_mem(6'b100011);
        run_instr(6'b000000, 6'b100000, 0, 0);
        run_instr(6'b111111, 6'($urandom), 0, 0);
        for (int n = 0; n < 80; n++) begin
            sel = $urandom_range(0, 10);
            fn  = 6'($urandom);
            case (sel)
                0, 1: begin op = 6'b000000; fn = r_funcs[$urandom_range(0, 4)]; end
                2:    begin op = 6'b000000; fn = 6'b001000; end
                3:    op = 6'b100011;
                4:    op = 6'b101011;
                5:    op = ($urandom_range(0, 1) == 1) ? 6'b001000 : 6'b001010;
                6:    op = 6'b000100;
                7:    op = 6'b000010;
                8:    op = 6'b000011;
                9:    op = bad_ops[$urandom_range(0, 4)];
                default: begin op = 6'b000000; fn = bad_fns[$urandom_range(0, 3)]; end
            endcase
            run_instr(op, fn, $urandom_range(0, 2), $urandom_range(0, 3));
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
